ps2_key_decoder: RTL

- Converts raw PS/2 keyboard clock/data lines into the 11-bit MiSTer ps2_key event bus consumed by the Saturn keyboard emulation and other keyboard consumers.
- Bus format: [10] toggle, [9] pressed, [8] E0 extended, [7:0] set-2 code.
- Handles line synchronisation, glitch filtering, 11-bit frame reception, parity/stop checking, frame timeout, and set-2 prefix decoding (E0, F0, E1 Pause).
- Filters out keyboard protocol responses.

---
 rtl/ps2_key_decoder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_key_decoder: PS/2 line receiver and set-2 decoder driving the 11-bit  |
// | ps2_key event bus {toggle, pressed, ext, code}.          Revision: 1.0    |
// +----------------------------------------------------------------------------+
module ps2_key_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 54000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    P_NONE    = 3'd0,
    P_EXT     = 3'd1,
    P_BRK     = 3'd2,
    P_EXT_BRK = 3'd3,
    P_SKIP    = 3'd4
  } pstate_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic [1:0]             sync_out;
  logic [1:0]             filt;
  logic                   clk_prev;
  logic                   fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
      clk_prev  <= filt[0];
    end
  end

  assign sync_out = {data_sync[SYNC_STAGES-1], clk_sync[SYNC_STAGES-1]};

  // lane 0 = PS/2 clock, lane 1 = PS/2 data
  for (genvar g = 0; g < 2; g++) begin : g_filter
    logic          level;
    logic [FW-1:0] run;

    always_ff @(posedge clk) begin
      if (reset) begin
        level <= 1'b1;
        run   <= '0;
      end else if (sync_out[g] == level) begin
        run <= '0;
      end else if (run == FW'(FILTER_LEN - 1)) begin
        level <= sync_out[g];
        run   <= '0;
      end else begin
        run <= run + 1'b1;
      end
    end

    assign filt[g] = level;
  end

  assign fall = clk_prev & ~filt[0];

  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= 4'd0;
      shift      <= 8'd0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
      frame_err  <= 1'b0;
      abort      <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      abort      <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        case (bit_cnt)
          4'd0: begin
            if (filt[1]) frame_err <= 1'b1;
            else         bit_cnt   <= 4'd1;
          end
          4'd9: begin
            par_bit <= filt[1];
            bit_cnt <= 4'd10;
          end
          4'd10: begin
            bit_cnt <= 4'd0;
            if (filt[1] && (^{shift, par_bit})) begin
              byte_valid <= 1'b1;
              byte_data  <= shift;
            end else begin
              frame_err <= 1'b1;
              abort     <= 1'b1;
            end
          end
          default: begin
            shift   <= {filt[1], shift[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end
        endcase
      end else if (bit_cnt != 4'd0) begin
        if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt   <= 4'd0;
          to_cnt    <= '0;
          frame_err <= 1'b1;
          abort     <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

  pstate_t     state, state_next;
  logic [2:0]  skip_cnt, skip_next;
  logic        emit;
  logic        is_ext, is_brk;
  logic [10:0] key_next;

  assign is_ext = (state == P_EXT) || (state == P_EXT_BRK);
  assign is_brk = (state == P_BRK) || (state == P_EXT_BRK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= P_NONE;
      skip_cnt <= 3'd0;
      ps2_key  <= 11'd0;
    end else begin
      state    <= state_next;
      skip_cnt <= skip_next;
      if (emit) ps2_key <= key_next;
    end
  end

  // Skip is checked first so the second E1 inside the Pause sequence is swallowed too
  always_comb begin
    state_next = state;
    skip_next  = skip_cnt;
    emit       = 1'b0;
    key_next   = {~ps2_key[10], ~is_brk, is_ext, byte_data};
    if (abort) begin
      state_next = P_NONE;
    end else if (byte_valid) begin
      if (state == P_SKIP) begin
        skip_next = skip_cnt - 3'd1;
        if (skip_cnt == 3'd1) state_next = P_NONE;
      end else begin
        case (byte_data)
          8'hE1: begin
            state_next = P_SKIP;
            skip_next  = 3'd7;
          end
          8'hE0: state_next = is_brk ? P_EXT_BRK : P_EXT;
          8'hF0: state_next = is_ext ? P_EXT_BRK : P_BRK;
          8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: state_next = P_NONE;
          default: begin
            state_next = P_NONE;
            emit       = !(is_ext && ((byte_data == 8'h12) || (byte_data == 8'h59)));
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
